// File: rtl/trig_seq_pkg.sv
// rtl/trig_seq_pkg.sv - shared constants, state enum and byte helpers for reg_trigger_seq
package trig_seq_pkg;

    // Register byte offsets within the block's address.
    localparam logic [15:0] BYTE_MASK_LO = 16'd0;
    localparam logic [15:0] BYTE_MASK_HI = 16'd1;
    localparam logic [15:0] BYTE_INV_LO  = 16'd2;
    localparam logic [15:0] BYTE_INV_HI  = 16'd3;
    localparam logic [15:0] BYTE_MODE    = 16'd4;
    localparam logic [15:0] BYTE_DELAY   = 16'd5;
    localparam logic [15:0] BYTE_WIDTH   = 16'd9;
    localparam logic [15:0] BYTE_HOLDOFF = 16'd13;
    localparam logic [15:0] BYTE_STATUS  = 16'd17;
    localparam logic [15:0] REG_LEN      = 16'd18;

    // Mode byte bit indices.
    localparam int MODE_AND_BIT  = 0;
    localparam int MODE_EDGE_BIT = 1;

    localparam logic [5:0] MISSED_MAX = 6'd63;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        PULSE   = 2'd2,
        HOLDOFF = 2'd3
    } seq_state_t;

    // Replace one little-endian byte lane of a 32-bit value.
    function automatic logic [31:0] put_byte(input logic [31:0] v,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = v;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Extract one little-endian byte lane of a 32-bit value.
    function automatic logic [7:0] get_byte(input logic [31:0] v,
                                            input logic [1:0]  lane);
        logic [7:0] r;
        case (lane)
            2'd0:    r = v[7:0];
            2'd1:    r = v[15:8];
            2'd2:    r = v[23:16];
            default: r = v[31:24];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/trig_sync_n.sv
// rtl/trig_sync_n.sv - N-wide two-flop synchroniser with synchronous reset
//
// Ports:
//   clk       destination clock
//   reset_i   synchronous active-high reset, clears both stages
//   async_in  asynchronous inputs
//   sync_out  inputs after two flops in the clk domain
module trig_sync_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/reg_trigger_seq.sv
// rtl/reg_trigger_seq.sv - register-bus trigger combiner with delay/width/holdoff sequencer
//
// Ports:
//   clk, reset_i               register-bus clock, synchronous active-high reset
//   reg_address/bytecnt/datai  register bus write/read addressing and write data
//   reg_read/write/addrvalid   bus strobes and address qualifier
//   reg_size                   transfer size (not used)
//   reg_hypaddress/reg_hyplen  register length query (18 bytes at REG_ADDR)
//   reg_datao                  read data, 0 when this block is not selected
//   reg_stream                 always 0
//   trig_in                    asynchronous trigger sources
//   trigger_o                  sequenced trigger pulse
//   busy_o                     high whenever the sequencer is not idle
module reg_trigger_seq
    import trig_seq_pkg::*;
#(
    parameter int         N_INPUTS  = 8,
    parameter int         CNT_WIDTH = 16,
    parameter logic [5:0] REG_ADDR  = 6'd40
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic [5:0]          reg_address,
    input  logic [15:0]         reg_bytecnt,
    input  logic [7:0]          reg_datai,
    output logic [7:0]          reg_datao,
    input  logic [15:0]         reg_size,
    input  logic                reg_read,
    input  logic                reg_write,
    input  logic                reg_addrvalid,
    input  logic [5:0]          reg_hypaddress,
    output logic [15:0]         reg_hyplen,
    output logic                reg_stream,
    input  logic [N_INPUTS-1:0] trig_in,
    output logic                trigger_o,
    output logic                busy_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // ---------------- register file ----------------
    logic                 sel_wr, sel_rd;
    logic [15:0]          en_q, inv_q;
    logic [1:0]           mode_q;
    logic [CNT_WIDTH-1:0] d_q, w_q, h_q;
    logic [5:0]           missed_q;
    logic                 in_d, in_w, in_h;
    logic [15:0]          off_d, off_w, off_h;
    logic [31:0]          d_wr, w_wr, h_wr;

    assign sel_wr = reg_write & reg_addrvalid & (reg_address == REG_ADDR);
    assign sel_rd = reg_read  & reg_addrvalid & (reg_address == REG_ADDR);

    assign in_d  = (reg_bytecnt >= BYTE_DELAY)   && (reg_bytecnt < BYTE_WIDTH);
    assign in_w  = (reg_bytecnt >= BYTE_WIDTH)   && (reg_bytecnt < BYTE_HOLDOFF);
    assign in_h  = (reg_bytecnt >= BYTE_HOLDOFF) && (reg_bytecnt < BYTE_STATUS);
    assign off_d = reg_bytecnt - BYTE_DELAY;
    assign off_w = reg_bytecnt - BYTE_WIDTH;
    assign off_h = reg_bytecnt - BYTE_HOLDOFF;

    // Counters are byte-written as 32-bit values; bits above CNT_WIDTH are dropped.
    assign d_wr = put_byte(32'(d_q), off_d[1:0], reg_datai);
    assign w_wr = put_byte(32'(w_q), off_w[1:0], reg_datai);
    assign h_wr = put_byte(32'(h_q), off_h[1:0], reg_datai);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            en_q   <= '0;
            inv_q  <= '0;
            mode_q <= '0;
            d_q    <= '0;
            w_q    <= CNT_ONE;
            h_q    <= '0;
        end else if (sel_wr) begin
            if (reg_bytecnt == BYTE_MASK_LO) en_q[7:0]   <= reg_datai;
            if (reg_bytecnt == BYTE_MASK_HI) en_q[15:8]  <= reg_datai;
            if (reg_bytecnt == BYTE_INV_LO)  inv_q[7:0]  <= reg_datai;
            if (reg_bytecnt == BYTE_INV_HI)  inv_q[15:8] <= reg_datai;
            if (reg_bytecnt == BYTE_MODE)    mode_q      <= reg_datai[1:0];
            if (in_d) d_q <= d_wr[CNT_WIDTH-1:0];
            if (in_w) w_q <= w_wr[CNT_WIDTH-1:0];
            if (in_h) h_q <= h_wr[CNT_WIDTH-1:0];
        end
    end

    // ---------------- combiner ----------------
    logic [N_INPUTS-1:0] trig_s, en_n, terms;
    logic                comb, comb_q, comb_prev, fire;

    trig_sync_n #(.WIDTH(N_INPUTS)) u_sync (
        .clk      (clk),
        .reset_i  (reset_i),
        .async_in (trig_in),
        .sync_out (trig_s)
    );

    assign en_n  = en_q[N_INPUTS-1:0];
    assign terms = (trig_s ^ inv_q[N_INPUTS-1:0]) & en_n;

    // AND mode treats disabled inputs as don't-care; an empty mask never fires.
    always_comb begin
        comb = 1'b0;
        if (en_n != '0) begin
            if (mode_q[MODE_AND_BIT]) comb = &(terms | ~en_n);
            else                      comb = |terms;
        end
    end

    assign fire = mode_q[MODE_EDGE_BIT] ? (comb_q & ~comb_prev) : comb_q;

    // ---------------- sequencer ----------------
    seq_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] w_lat, h_lat, w_eff;
    logic                 latch_cfg;
    logic                 trigger_q, busy_q;

    assign w_eff = (w_q == '0) ? CNT_ONE : w_q;

    // D goes straight into the counter at fire, so only W and H need latching.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_cfg = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    latch_cfg = 1'b1;
                    if (d_q != '0) begin
                        state_d = DELAY;
                        cnt_d   = d_q - CNT_ONE;
                    end else begin
                        state_d = PULSE;
                        cnt_d   = w_eff - CNT_ONE;
                    end
                end
            end
            DELAY: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = w_lat - CNT_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    if (h_lat != '0) begin
                        state_d = HOLDOFF;
                        cnt_d   = h_lat - CNT_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            w_lat     <= CNT_ONE;
            h_lat     <= '0;
            comb_q    <= 1'b0;
            comb_prev <= 1'b0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            comb_q    <= comb;
            comb_prev <= comb_q;
            trigger_q <= (state_d == PULSE);
            busy_q    <= (state_d != IDLE);
            if (latch_cfg) begin
                w_lat <= w_eff;
                h_lat <= h_q;
            end
        end
    end

    // A status write in the same cycle as a missed fire clears the count.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            missed_q <= '0;
        end else if (sel_wr && reg_bytecnt == BYTE_STATUS) begin
            missed_q <= '0;
        end else if (fire && state_q != IDLE && missed_q != MISSED_MAX) begin
            missed_q <= missed_q + 6'd1;
        end
    end

    assign trigger_o = trigger_q;
    assign busy_o    = busy_q;

    // ---------------- readback ----------------
    logic [7:0] rd_byte;

    always_comb begin
        rd_byte = 8'h00;
        if (reg_bytecnt == BYTE_MASK_LO) rd_byte = en_q[7:0];
        if (reg_bytecnt == BYTE_MASK_HI) rd_byte = en_q[15:8];
        if (reg_bytecnt == BYTE_INV_LO)  rd_byte = inv_q[7:0];
        if (reg_bytecnt == BYTE_INV_HI)  rd_byte = inv_q[15:8];
        if (reg_bytecnt == BYTE_MODE)    rd_byte = {6'b0, mode_q};
        if (in_d) rd_byte = get_byte(32'(d_q), off_d[1:0]);
        if (in_w) rd_byte = get_byte(32'(w_q), off_w[1:0]);
        if (in_h) rd_byte = get_byte(32'(h_q), off_h[1:0]);
        if (reg_bytecnt == BYTE_STATUS)  rd_byte = {missed_q, state_q};
    end

    assign reg_datao  = sel_rd ? rd_byte : 8'h00;
    assign reg_hyplen = (reg_hypaddress == REG_ADDR) ? REG_LEN : 16'd0;
    assign reg_stream = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{reg_size, en_q, inv_q};

endmodule

// File: tb/tb_reg_trigger_seq.sv
// tb/tb_reg_trigger_seq.sv - directed self-checking bench for reg_trigger_seq
module tb_reg_trigger_seq;

    localparam int         N    = 8;
    localparam int         CW   = 16;
    localparam logic [5:0] ADDR = 6'd40;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [5:0]   reg_address;
    logic [15:0]  reg_bytecnt;
    logic [7:0]   reg_datai;
    logic [7:0]   reg_datao;
    logic [15:0]  reg_size;
    logic         reg_read;
    logic         reg_write;
    logic         reg_addrvalid;
    logic [5:0]   reg_hypaddress;
    logic [15:0]  reg_hyplen;
    logic         reg_stream;
    logic [N-1:0] trig_in;
    logic         trigger_o;
    logic         busy_o;

    always #5 clk = ~clk;

    reg_trigger_seq #(.N_INPUTS(N), .CNT_WIDTH(CW), .REG_ADDR(ADDR)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .reg_address    (reg_address),
        .reg_bytecnt    (reg_bytecnt),
        .reg_datai      (reg_datai),
        .reg_datao      (reg_datao),
        .reg_size       (reg_size),
        .reg_read       (reg_read),
        .reg_write      (reg_write),
        .reg_addrvalid  (reg_addrvalid),
        .reg_hypaddress (reg_hypaddress),
        .reg_hyplen     (reg_hyplen),
        .reg_stream     (reg_stream),
        .trig_in        (trig_in),
        .trigger_o      (trigger_o),
        .busy_o         (busy_o)
    );

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [15:0] en;
        logic [7:0]  inv;
        logic [7:0]  mode;
        logic [7:0]  trig;
        logic        exp;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wr(input logic [15:0] b, input logic [7:0] d);
        reg_address   = ADDR;
        reg_addrvalid = 1'b1;
        reg_write     = 1'b1;
        reg_bytecnt   = b;
        reg_datai     = d;
        step();
        reg_write     = 1'b0;
        reg_addrvalid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] b, output logic [7:0] d);
        reg_address   = ADDR;
        reg_addrvalid = 1'b1;
        reg_read      = 1'b1;
        reg_bytecnt   = b;
        #2;
        d             = reg_datao;
        reg_read      = 1'b0;
        reg_addrvalid = 1'b0;
        step();
    endtask

    task automatic wr32(input logic [15:0] base, input logic [31:0] v);
        wr(base,        v[7:0]);
        wr(base + 16'd1, v[15:8]);
        wr(base + 16'd2, v[23:16]);
        wr(base + 16'd3, v[31:24]);
    endtask

    // Enable mask is written last so nothing fires while the rest is set up.
    task automatic cfg(input logic [15:0] en, input logic [7:0] inv, input logic [7:0] mode,
                       input logic [31:0] d, input logic [31:0] w, input logic [31:0] h);
        wr(16'd0, 8'h00);
        wr(16'd1, 8'h00);
        wr(16'd2, inv);
        wr(16'd3, 8'h00);
        wr(16'd4, mode);
        wr32(16'd5,  d);
        wr32(16'd9,  w);
        wr32(16'd13, h);
        wr(16'd1, en[15:8]);
        wr(16'd0, en[7:0]);
    endtask

    task automatic check_reset_regs(input string tag);
        logic [7:0] v;
        for (int b = 0; b < 18; b++) begin
            rd(16'(b), v);
            check($sformatf("%s_b%0d", tag, b), 32'(v), (b == 9) ? 32'h1 : 32'h0);
        end
    endtask

    initial begin
        logic [7:0] v;
        int hi;

        vecs[0]  = '{16'h0001, 8'h00, 8'h00, 8'h01, 1'b1};
        vecs[1]  = '{16'h0001, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{16'h0003, 8'h02, 8'h01, 8'h01, 1'b1};
        vecs[3]  = '{16'h0003, 8'h02, 8'h01, 8'h03, 1'b0};
        vecs[4]  = '{16'h0003, 8'h00, 8'h00, 8'h02, 1'b1};
        vecs[5]  = '{16'h0000, 8'h00, 8'h01, 8'hff, 1'b0};
        vecs[6]  = '{16'h0000, 8'hff, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{16'h00f0, 8'h00, 8'h01, 8'hf0, 1'b1};
        vecs[8]  = '{16'h00f0, 8'h00, 8'h01, 8'h70, 1'b0};
        vecs[9]  = '{16'h0004, 8'h00, 8'h02, 8'h04, 1'b1};
        vecs[10] = '{16'h0100, 8'h00, 8'h00, 8'hff, 1'b0};

        reset_i = 1'b1;
        reg_address = '0; reg_bytecnt = '0; reg_datai = '0; reg_size = '0;
        reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
        reg_hypaddress = '0; trig_in = '0;
        repeat (3) step();
        check("rst_trigger", 32'(trigger_o), 32'h0);
        check("rst_busy",    32'(busy_o),    32'h0);
        reset_i = 1'b0;
        step();
        check_reset_regs("rst");

        // Combiner vectors with D=0, W=1, H=0.
        for (int i = 0; i < 11; i++) begin
            trig_in = vecs[i].trig;
            cfg(vecs[i].en, vecs[i].inv, vecs[i].mode, 32'd0, 32'd1, 32'd0);
            step();
            check($sformatf("vec%0d_early", i), 32'(trigger_o), 32'h0);
            step();
            check($sformatf("vec%0d", i), 32'(trigger_o), 32'(vecs[i].exp));
            wr(16'd0, 8'h00);
            wr(16'd1, 8'h00);
            trig_in = '0;
            repeat (4) step();
            check($sformatf("vec%0d_idle", i), 32'(busy_o), 32'h0);
        end

        // Level OR, single-cycle input pulse.
        cfg(16'h0001, 8'h00, 8'h00, 32'd0, 32'd1, 32'd0);
        trig_in = 8'h01;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 1) trig_in = '0;
            check($sformatf("lvl_trig_e%0d", e), 32'(trigger_o), (e == 4) ? 32'h1 : 32'h0);
        end

        // Edge mode, D=10, W=5.
        cfg(16'h0004, 8'h00, 8'h02, 32'd10, 32'd5, 32'd0);
        trig_in = 8'h04;
        for (int e = 1; e <= 22; e++) begin
            step();
            check($sformatf("dw_trig_e%0d", e), 32'(trigger_o), (e >= 14 && e <= 18) ? 32'h1 : 32'h0);
            check($sformatf("dw_busy_e%0d", e), 32'(busy_o),    (e >= 4  && e <= 18) ? 32'h1 : 32'h0);
        end
        trig_in = '0;
        repeat (3) step();

        // Holdoff H=20 with three edges arriving during holdoff.
        cfg(16'h0001, 8'h00, 8'h02, 32'd0, 32'd1, 32'd20);
        wr(16'd17, 8'h00);
        trig_in = 8'h01;
        step();
        trig_in = '0;
        repeat (3) step();
        check("ho_pulse", 32'(trigger_o), 32'h1);
        hi = 0;
        for (int p = 0; p < 3; p++) begin
            trig_in = 8'h01;
            step(); hi += int'(trigger_o);
            step(); hi += int'(trigger_o);
            trig_in = '0;
            step(); hi += int'(trigger_o);
            step(); hi += int'(trigger_o);
        end
        for (int k = 0; k < 12; k++) begin
            step(); hi += int'(trigger_o);
        end
        check("ho_no_pulse", 32'(hi), 32'h0);
        check("ho_idle", 32'(busy_o), 32'h0);
        rd(16'd17, v);
        check("ho_missed3", 32'(v), 32'h0c);
        wr(16'd17, 8'hff);
        rd(16'd17, v);
        check("ho_missed_clr", 32'(v), 32'h00);

        // Reset in the middle of a long pulse.
        cfg(16'h0001, 8'h00, 8'h02, 32'd0, 32'd100, 32'd0);
        trig_in = 8'h01;
        step();
        trig_in = '0;
        repeat (3) step();
        check("rp_high", 32'(trigger_o), 32'h1);
        repeat (3) step();
        check("rp_still_high", 32'(trigger_o), 32'h1);
        reset_i = 1'b1;
        step();
        check("rp_trig_drop", 32'(trigger_o), 32'h0);
        check("rp_busy_drop", 32'(busy_o),    32'h0);
        reset_i = 1'b0;
        step();
        check_reset_regs("rp");

        // Readback latency and counter truncation above CNT_WIDTH.
        wr(16'd9, 8'hab);
        rd(16'd9, v);
        check("rb_w0", 32'(v), 32'hab);
        wr(16'd12, 8'h55);
        rd(16'd12, v);
        check("rb_w3_trunc", 32'(v), 32'h00);

        // Bus decode.
        reg_address = ADDR + 6'd1; reg_addrvalid = 1'b1; reg_read = 1'b1; reg_bytecnt = 16'd9;
        #2;
        check("dec_other_addr", 32'(reg_datao), 32'h0);
        reg_address = ADDR; reg_addrvalid = 1'b0;
        #2;
        check("dec_no_valid", 32'(reg_datao), 32'h0);
        reg_read = 1'b0;
        reg_hypaddress = ADDR;
        #1;
        check("hyplen_sel", 32'(reg_hyplen), 32'd18);
        reg_hypaddress = 6'd3;
        #1;
        check("hyplen_other", 32'(reg_hyplen), 32'd0);
        check("stream", 32'(reg_stream), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
